// File: rtl/m_sprite_renderer.sv
// Sprite renderer: once per game tick, erases the previous 5x5 tiles of the player and three
// ghosts, then redraws all four at their new tiles. Every pixel goes out as one registered VGA write.
module m_sprite_renderer #(
  parameter logic [2:0] BG_COLOR     = 3'b000,
  parameter logic [2:0] PLAYER_COLOR = 3'b110,
  parameter logic [2:0] G1_COLOR     = 3'b100,
  parameter logic [2:0] G2_COLOR     = 3'b101,
  parameter logic [2:0] G3_COLOR     = 3'b011
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [4:0] player_x,
  input  logic [3:0] player_y,
  input  logic [4:0] ghost1_x,
  input  logic [3:0] ghost1_y,
  input  logic [4:0] ghost2_x,
  input  logic [3:0] ghost2_y,
  input  logic [4:0] ghost3_x,
  input  logic [3:0] ghost3_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       finished,
  output logic       busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ERASE = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] r_state;
  logic [4:0] r_new_x [4];
  logic [3:0] r_new_y [4];
  logic [4:0] r_old_x [4];
  logic [3:0] r_old_y [4];
  logic       r_old_valid;
  logic [2:0] r_px;
  logic [2:0] r_py;
  logic [1:0] r_sprite;

  logic [4:0] w_tile_x;
  logic [3:0] w_tile_y;
  logic [7:0] w_pix_x;
  logic [6:0] w_pix_y;
  logic [2:0] w_sprite_color;
  logic       w_last_pix;
  logic       w_last_sprite;

  // ERASE walks the previous tiles, DRAW the freshly latched ones.
  assign w_tile_x = (r_state == S_ERASE) ? r_old_x[r_sprite] : r_new_x[r_sprite];
  assign w_tile_y = (r_state == S_ERASE) ? r_old_y[r_sprite] : r_new_y[r_sprite];
  assign w_pix_x  = ({3'b000, w_tile_x} * 8'd5) + {5'b00000, r_px};
  assign w_pix_y  = ({3'b000, w_tile_y} * 7'd5) + {4'b0000, r_py};
  assign w_last_pix    = (r_px == 3'd4) && (r_py == 3'd4);
  assign w_last_sprite = (r_sprite == 2'd3);

  always_comb begin
    w_sprite_color = PLAYER_COLOR;
    case (r_sprite)
      2'd1:    w_sprite_color = G1_COLOR;
      2'd2:    w_sprite_color = G2_COLOR;
      2'd3:    w_sprite_color = G3_COLOR;
      default: w_sprite_color = PLAYER_COLOR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_old_valid <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_sprite    <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_color   <= '0;
      vga_plot    <= 1'b0;
      finished    <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_new_x[i] <= '0;
        r_new_y[i] <= '0;
        r_old_x[i] <= '0;
        r_old_y[i] <= '0;
      end
    end else begin
      vga_plot <= 1'b0;
      finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_LOAD;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_new_x[0] <= player_x;
          r_new_y[0] <= player_y;
          r_new_x[1] <= ghost1_x;
          r_new_y[1] <= ghost1_y;
          r_new_x[2] <= ghost2_x;
          r_new_y[2] <= ghost2_y;
          r_new_x[3] <= ghost3_x;
          r_new_y[3] <= ghost3_y;
          r_px       <= '0;
          r_py       <= '0;
          r_sprite   <= '0;
          r_state    <= r_old_valid ? S_ERASE : S_DRAW;
        end
        S_ERASE, S_DRAW: begin
          vga_x     <= w_pix_x;
          vga_y     <= w_pix_y;
          vga_color <= (r_state == S_ERASE) ? BG_COLOR : w_sprite_color;
          vga_plot  <= 1'b1;
          // Row-major walk; the sprite index wraps 3 -> 0 ready for the next pass.
          if (r_px == 3'd4) begin
            r_px <= '0;
            if (r_py == 3'd4) begin
              r_py     <= '0;
              r_sprite <= r_sprite + 2'd1;
            end else begin
              r_py <= r_py + 3'd1;
            end
          end else begin
            r_px <= r_px + 3'd1;
          end
          if (w_last_pix && w_last_sprite) begin
            if (r_state == S_ERASE) begin
              r_state <= S_DRAW;
            end else begin
              for (int i = 0; i < 4; i++) begin
                r_old_x[i] <= r_new_x[i];
                r_old_y[i] <= r_new_y[i];
              end
              r_old_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          finished <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_m_sprite_renderer.sv
// Bench for m_sprite_renderer: frames with directed and random sprite positions, compared against a
// pixel-list model of the erase/draw rules and a modelled framebuffer.
module tb_m_sprite_renderer;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] in_x [4];
  logic [3:0] in_y [4];
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;
  logic       vga_plot;
  logic       finished;
  logic       busy;

  logic [2:0] col [4];
  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard state: expected plot stream {x, y, colour} and modelled framebuffers.
  logic [17:0] exp_q [$];
  logic [17:0] obs_log [$];
  logic [2:0]  obs_fb [160][80];
  logic [2:0]  exp_fb [160][80];
  logic [4:0]  m_old_x [4];
  logic [3:0]  m_old_y [4];
  bit          m_old_valid = 0;
  bit          mon_en = 0;
  int          plot_cnt = 0;

  m_sprite_renderer dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .player_x(in_x[0]), .player_y(in_y[0]),
    .ghost1_x(in_x[1]), .ghost1_y(in_y[1]),
    .ghost2_x(in_x[2]), .ghost2_y(in_y[2]),
    .ghost3_x(in_x[3]), .ghost3_y(in_y[3]),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_plot(vga_plot), .finished(finished), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] get_log(input int i);
    if (i < obs_log.size()) return obs_log[i];
    return 18'h3ffff;
  endfunction

  function automatic logic [17:0] pix(input int tx, input int ty, input int px, input int py,
                                      input logic [2:0] c);
    int xv;
    int yv;
    xv = tx * 5 + px;
    yv = ty * 5 + py;
    return {xv[7:0], yv[6:0], c};
  endfunction

  // Reference: erase every old tile (if any), then draw every new tile, in sprite order.
  task automatic build_expected();
    exp_q.delete();
    if (m_old_valid)
      for (int s = 0; s < 4; s++)
        for (int py = 0; py < 5; py++)
          for (int px = 0; px < 5; px++)
            exp_q.push_back(pix(m_old_x[s], m_old_y[s], px, py, 3'b000));
    for (int s = 0; s < 4; s++)
      for (int py = 0; py < 5; py++)
        for (int px = 0; px < 5; px++)
          exp_q.push_back(pix(in_x[s], in_y[s], px, py, col[s]));
    for (int s = 0; s < 4; s++) begin
      m_old_x[s] = in_x[s];
      m_old_y[s] = in_y[s];
    end
    m_old_valid = 1;
  endtask

  always @(negedge clock) begin
    logic [17:0] e;
    if (mon_en) begin
      if (vga_plot) begin
        plot_cnt++;
        obs_log.push_back({vga_x, vga_y, vga_color});
        if (vga_x < 160 && vga_y < 80) obs_fb[vga_x][vga_y] = vga_color;
        if (exp_q.size() == 0) begin
          check_val("extra_plot", 1, 0);
        end else begin
          e = exp_q.pop_front();
          exp_fb[e[17:10]][e[9:3]] = e[2:0];
          check_val("plot", {vga_x, vga_y, vga_color}, e);
        end
        check_val("plot_while_busy", busy, 1);
      end
      if (finished) check_val("plot_in_done", vga_plot, 0);
    end
  end

  task automatic check_fb();
    int bad;
    bad = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 80; y++)
        if (obs_fb[x][y] !== exp_fb[x][y]) bad++;
    check_val("framebuffer", bad, 0);
  endtask

  task automatic randomize_pos();
    for (int s = 0; s < 4; s++) begin
      in_x[s] = 5'($urandom_range(0, 31));
      in_y[s] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic set_pos(input int s, input int x, input int y);
    in_x[s] = 5'(x);
    in_y[s] = 4'(y);
  endtask

  task automatic do_frame(input int exp_n, input bit hold);
    int cyc;
    @(negedge clock);
    enable = 1'b1;
    build_expected();
    plot_cnt = 0;
    obs_log.delete();
    @(posedge clock);
    #1;
    if (!hold) enable = 1'b0;
    check_val("busy_rise", busy, 1);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 1) begin
        check_val("plot_in_load", vga_plot, 0);
        randomize_pos();
      end
    end while (!finished && cyc < 1000);
    check_val("latency", cyc, exp_n + 2);
    check_val("plot_count", plot_cnt, exp_n);
    check_val("queue_drained", exp_q.size(), 0);
    check_val("busy_fall", busy, 0);
    check_fb();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    col[0] = 3'b110; col[1] = 3'b100; col[2] = 3'b101; col[3] = 3'b011;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 80; y++) begin
        obs_fb[x][y] = 3'b000;
        exp_fb[x][y] = 3'b000;
      end
    for (int s = 0; s < 4; s++) set_pos(s, 0, 0);

    repeat (3) @(posedge clock);
    #1;
    check_val("rst_x", vga_x, 0);
    check_val("rst_y", vga_y, 0);
    check_val("rst_color", vga_color, 0);
    check_val("rst_plot", vga_plot, 0);
    check_val("rst_finished", finished, 0);
    check_val("rst_busy", busy, 0);
    @(negedge clock);
    resetn = 1'b1;
    mon_en = 1;

    set_pos(0, 1, 1); set_pos(1, 3, 2); set_pos(2, 10, 5); set_pos(3, 28, 13);
    do_frame(100, 0);
    check_val("f1_first", get_log(0), {8'd5, 7'd5, 3'b110});
    check_val("f1_26th", get_log(25), {8'd15, 7'd10, 3'b100});
    check_val("f1_last", get_log(99), {8'd144, 7'd69, 3'b011});

    set_pos(0, 2, 1); set_pos(1, 3, 2); set_pos(2, 10, 5); set_pos(3, 28, 13);
    do_frame(200, 0);
    check_val("f2_first", get_log(0), {8'd5, 7'd5, 3'b000});
    check_val("f2_101st", get_log(100), {8'd10, 7'd5, 3'b110});

    set_pos(0, 4, 4); set_pos(1, 4, 4); set_pos(2, 0, 0); set_pos(3, 31, 15);
    do_frame(200, 0);
    for (int x = 20; x < 25; x++)
      for (int y = 20; y < 25; y++)
        check_val("overlap_g1_wins", obs_fb[x][y], 3'b100);

    set_pos(0, 31, 15); set_pos(1, 0, 0); set_pos(2, 1, 0); set_pos(3, 2, 0);
    do_frame(200, 0);
    check_val("corner_pixel", get_log(124), {8'd159, 7'd79, 3'b110});
    check_val("corner_fb", obs_fb[159][79], 3'b110);

    repeat (4) begin
      randomize_pos();
      do_frame(200, 0);
    end

    // Abort a frame with reset 50 cycles into DRAW.
    randomize_pos();
    @(negedge clock);
    enable = 1'b1;
    build_expected();
    plot_cnt = 0;
    @(posedge clock);
    #1;
    enable = 1'b0;
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (plot_cnt < 150 && cyc < 1000);
    check_val("abort_reached", plot_cnt, 150);
    resetn = 1'b0;
    mon_en = 0;
    @(posedge clock);
    #1;
    check_val("abort_plot", vga_plot, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_finished", finished, 0);
    @(posedge clock);
    #1;
    check_val("abort_plot_hold", vga_plot, 0);
    exp_q.delete();
    m_old_valid = 0;
    @(negedge clock);
    resetn = 1'b1;
    mon_en = 1;

    randomize_pos();
    do_frame(100, 0);

    // Enable held across a whole frame: the next frame begins once IDLE is back.
    randomize_pos();
    do_frame(200, 1);
    randomize_pos();
    do_frame(200, 0);

    repeat (3) @(posedge clock);
    #1;
    check_val("idle_plot", vga_plot, 0);
    check_val("idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
